line_tap_buffer: RTL and testbench
==================================

# line_tap_buffer

Parametrised, valid-gated line buffer for the convolution datapath: replaces fixed-length register delay chains with K taps spaced by a runtime-programmable line length L. Each push returns K vertically aligned samples, each L pushes apart, for a K-row convolution window. It sits between the pixel source and the K×K MAC array.

## Interface

- N, 16, sample width in bits.
- DMAX, 27, maximum line length (row-buffer depth).
- K, 3, number of taps (window rows), K ≥ 2.
- LW, 5, width of ilen; must satisfy 2^LW > DMAX.
- iCLK  input  1  clock, rising edge.
- iRSTn  input  1  asynchronous active-low reset.
- iclr  input  1  synchronous flush and length load.
- ilen  input  LW  line length L; sampled only when iclr=1.
- ivalid  input  1  push strobe for idata.
- idata  input  N  sample.
- ovalid  output  1  otaps valid, single-cycle per push.
- otaps  output  N*K  tap k at otaps[N*k +: N], k=0..K-1.
- oprimed  output  1  level: buffer holds ≥ (K-1)*L samples.

## Operation

- Storage: K-1 row buffers of DMAX×N regs, one shared write pointer ptr (0..L-1), fill counter fcnt saturating at (K-1)*L.
- Length register L: reset value DMAX. Loaded from ilen on any cycle with iclr=1. If ilen=0 or ilen>DMAX, L=DMAX.
- Push (ivalid=1, iclr=0), with n = index of this push since last clear/reset, counted from 0:
  - Tap 0 gets idata. Tap k (k≥1) gets row[k-1][ptr], i.e. sample n-k*L.
  - Row writes: row[0][ptr] gets idata; row[j][ptr] gets the old row[j-1][ptr] for j≥1.
  - ptr increments and wraps from L-1 to 0.
  - fcnt increments, saturating.
- ovalid=1 on the cycle after a push only if the push had n ≥ (K-1)*L. Pushes before that update otaps but leave ovalid=0.
- oprimed=1 when fcnt=(K-1)*L, i.e. from the cycle after push n=(K-1)*L-1. Held until clear or reset.
- Idle (ivalid=0): no state change. otaps holds its value; ovalid=0.
- iclr=1: ptr=0, fcnt=0, otaps=0, ovalid=0, oprimed=0, L loaded. Row contents are not cleared; they are unobservable until refilled, because ovalid is gated.
- iclr and ivalid both high: clear wins and the sample is dropped.
- Async reset (iRSTn=0), at any time including mid-line: all rows, otaps, ptr and fcnt go to 0; ovalid=0; oprimed=0; L=DMAX. Outputs change immediately. First push after release is n=0.

## Timing

- Latency 1 cycle: push on edge t gives otaps/ovalid valid after edge t, observed in cycle t+1.
- Throughput: one push per cycle. Arbitrary ivalid bubbles allowed; taps stay aligned in push count, not cycles.
- No backpressure: the consumer must accept every ovalid pulse.
- A length change takes effect on the first push after the iclr cycle.
- Reset values: ovalid=0, oprimed=0, otaps=0.

## Test plan

- L=4, K=3, push 0,1,2,… back-to-back. ovalid stays 0 until push n=8. The cycle after push 8 shows ovalid=1 and taps {t0,t1,t2}={8,4,0}. After push 9: {9,5,1}. oprimed rises the cycle after push 7.
- Same stream with a random ivalid duty of ~50%. Tap values match the back-to-back case push for push. ovalid=0 and otaps stable on idle cycles.
- iclr with ilen=0, then 60 pushes. L=27; first ovalid follows push 54 with taps {54,27,0}. Repeat with ilen=31: same result.
- Mid-stream at n=20 with L=4: assert iclr+ivalid together with ilen=5. Sample is dropped, outputs cleared. Restart pushes at 100: first ovalid follows the 11th push, taps {110,105,100}.
- Reset pulse mid-line at n=6, asynchronous to the clock edge. Outputs go to 0 at once. After release: L=27, ptr wrap at 26 verified, first ovalid follows push 54.
- L=1, K=3: first ovalid follows push 2 with taps {2,1,0}. Every later push is valid.

Source files
------------

// File: rtl/line_tap_buffer.sv
// K-tap line buffer: each push returns K vertically aligned samples spaced L pushes apart.
// L is loaded on clear; the outputs stay gated until (K-1)*L samples have been collected.
module line_tap_buffer #(
  parameter int N    = 16,
  parameter int DMAX = 27,
  parameter int K    = 3,
  parameter int LW   = 5
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  input  logic           iclr,
  input  logic [LW-1:0]  ilen,
  input  logic           ivalid,
  input  logic [N-1:0]   idata,
  output logic           ovalid,
  output logic [N*K-1:0] otaps,
  output logic           oprimed
);

  localparam int AW = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int FW = $clog2((K - 1) * DMAX + 1);
  localparam logic [LW-1:0] DMAX_L = LW'(DMAX);

  // Zero or out-of-range lengths fall back to the full row depth.
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] len);
    if ((len == '0) || (len > DMAX_L)) return DMAX_L;
    return len;
  endfunction

  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  ptr_q, ptr_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [FW-1:0]  full_cnt;
  logic [N*K-1:0] taps_q, taps_d;
  logic           ovalid_q, ovalid_d;
  logic [N-1:0]   row_q [K-1][DMAX];
  logic [N-1:0]   row_d [K-1][DMAX];
  logic [AW-1:0]  wa;

  assign wa       = ptr_q[AW-1:0];
  assign full_cnt = FW'((K - 1) * len_q);

  always_comb begin
    len_d    = len_q;
    ptr_d    = ptr_q;
    fcnt_d   = fcnt_q;
    taps_d   = taps_q;
    ovalid_d = 1'b0;
    row_d    = row_q;
    if (iclr) begin
      len_d  = sat_len(ilen);
      ptr_d  = '0;
      fcnt_d = '0;
      taps_d = '0;
    end else if (ivalid) begin
      taps_d[N-1:0] = idata;
      for (int k = 1; k < K; k++) taps_d[N*k +: N] = row_q[k-1][wa];
      // All rows shift at the same column, so row j holds sample n-(j+1)*L.
      row_d[0][wa] = idata;
      for (int j = 1; j < K - 1; j++) row_d[j][wa] = row_q[j-1][wa];
      ptr_d = (ptr_q == len_q - LW'(1)) ? '0 : ptr_q + LW'(1);
      if (fcnt_q != full_cnt) fcnt_d = fcnt_q + FW'(1);
      ovalid_d = (fcnt_q == full_cnt);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      len_q    <= DMAX_L;
      ptr_q    <= '0;
      fcnt_q   <= '0;
      taps_q   <= '0;
      ovalid_q <= 1'b0;
      for (int j = 0; j < K - 1; j++)
        for (int a = 0; a < DMAX; a++) row_q[j][a] <= '0;
    end else begin
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      fcnt_q   <= fcnt_d;
      taps_q   <= taps_d;
      ovalid_q <= ovalid_d;
      row_q    <= row_d;
    end
  end

  assign ovalid  = ovalid_q;
  assign otaps   = taps_q;
  assign oprimed = (fcnt_q == full_cnt);

endmodule

// File: tb/tb_line_tap_buffer.sv
// Scoreboarded bench for line_tap_buffer (K=3): stimulus queues expected taps,
// a negedge monitor pops and compares on every ovalid pulse.
module tb_line_tap_buffer;
  localparam int N = 16, DMAX = 27, K = 3, LW = 5;

  logic           clk = 1'b0;
  logic           rst_n, iclr, ivalid;
  logic [LW-1:0]  ilen;
  logic [N-1:0]   idata;
  logic           ovalid, oprimed;
  logic [N*K-1:0] otaps;

  logic [N*K-1:0] exp_q[$];
  int hist[$];
  int lcur, nidx, vcount;
  int n_checks = 0, n_fail = 0;

  line_tap_buffer #(.N(N), .DMAX(DMAX), .K(K), .LW(LW)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iclr(iclr), .ilen(ilen), .ivalid(ivalid),
    .idata(idata), .ovalid(ovalid), .otaps(otaps), .oprimed(oprimed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ovalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && ovalid) begin
      vcount++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ovalid: got taps %0h expected no output", otaps);
      end else begin
        chk("taps", otaps, exp_q.pop_front());
      end
    end
  end

  function automatic logic [N*K-1:0] pack3(input int t0, input int t1, input int t2);
    return {N'(t2), N'(t1), N'(t0)};
  endfunction

  task automatic push(input int v);
    ivalid = 1'b1;
    iclr   = 1'b0;
    idata  = N'(v);
    hist.push_back(v);
    if (nidx >= 2 * lcur) exp_q.push_back(pack3(v, hist[nidx-lcur], hist[nidx-2*lcur]));
    @(posedge clk); #1;
    ivalid = 1'b0;
    nidx++;
    chk("oprimed", oprimed, (nidx >= 2 * lcur));
  endtask

  task automatic idle();
    logic [N*K-1:0] prev;
    prev   = otaps;
    ivalid = 1'b0;
    @(posedge clk); #1;
    chk("idle_taps", otaps, prev);
    chk("idle_ovalid", ovalid, 0);
  endtask

  task automatic clear(input int len, input bit with_valid);
    iclr   = 1'b1;
    ilen   = LW'(len);
    ivalid = with_valid;
    idata  = 16'hBEEF;
    @(posedge clk); #1;
    iclr   = 1'b0;
    ivalid = 1'b0;
    chk("pending_before_clear", exp_q.size(), 0);
    exp_q.delete();
    lcur   = (len == 0 || len > DMAX) ? DMAX : len;
    nidx   = 0;
    vcount = 0;
    hist.delete();
    chk("clr_taps", otaps, 0);
    chk("clr_ovalid", ovalid, 0);
    chk("clr_oprimed", oprimed, 0);
  endtask

  task automatic long_stream(input string name);
    for (int v = 0; v < 60; v++) begin
      push(v);
      if (v == 54) chk(name, otaps, pack3(54, 27, 0));
    end
    idle();
    chk("long_vcount", vcount, 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; iclr = 1'b0; ilen = '0; ivalid = 1'b0; idata = '0;
    lcur = DMAX; nidx = 0; vcount = 0;
    #12;
    chk("rst_taps", otaps, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_oprimed", oprimed, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // L=4 back-to-back
    clear(4, 0);
    for (int v = 0; v < 12; v++) begin
      push(v);
      if (v == 8) chk("l4_first", otaps, pack3(8, 4, 0));
      if (v == 9) chk("l4_second", otaps, pack3(9, 5, 1));
    end
    idle();
    chk("l4_vcount", vcount, 4);

    // L=4 with random bubbles
    clear(4, 0);
    for (int v = 0; v < 12; v++) begin
      push(v);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    chk("bubble_vcount", vcount, 4);

    // ilen=0 and ilen=31 both select the full depth
    clear(0, 0);
    long_stream("len0_first");
    clear(31, 0);
    long_stream("len31_first");

    // Clear coinciding with a push mid-stream; the sample must be dropped
    clear(4, 0);
    for (int v = 0; v < 20; v++) push(v);
    clear(5, 1);
    for (int v = 100; v < 112; v++) begin
      push(v);
      if (v == 110) chk("restart_first", otaps, pack3(110, 105, 100));
    end
    idle();
    chk("restart_vcount", vcount, 2);

    // Asynchronous reset mid-line
    clear(4, 0);
    for (int v = 0; v < 6; v++) push(v);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_taps", otaps, 0);
    chk("arst_ovalid", ovalid, 0);
    chk("arst_oprimed", oprimed, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    lcur = DMAX; nidx = 0; vcount = 0;
    hist.delete();
    long_stream("arst_first");

    // L=1
    clear(1, 0);
    for (int v = 0; v < 6; v++) begin
      push(v);
      if (v == 2) chk("l1_first", otaps, pack3(2, 1, 0));
    end
    idle();
    chk("l1_vcount", vcount, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
